// File: rtl/sync_lock_ctrl.sv
// Block-lock controller: drives a bit-offset seeker, confirms alignment with a run of valid sync headers,
// then monitors header quality per window. Optional SYNC_LOCK_STATS_EN adds a lock-loss counter port.
module sync_lock_ctrl #(
  parameter int LOCK_CNT = 32,
  parameter int WIN_LEN  = 64,
  parameter int BAD_MAX  = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        seek_synced_i,
  input  logic [6:0]  seek_offset_i,
  input  logic        seek_dv_i,
  input  logic [1:0]  hdr_i,
  input  logic        hdr_dv_i,
  output logic        seek_restart_o,
  output logic [6:0]  offset_o,
  output logic        locked_o,
`ifdef SYNC_LOCK_STATS_EN
  output logic [15:0] lock_loss_cnt_o,
`endif
  output logic [1:0]  state_o
);

  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam int WW = $clog2(WIN_LEN + 1);
  localparam int BW = $clog2(BAD_MAX + 1);

  typedef enum logic [1:0] {
    S_RESTART = 2'd0,
    S_SEARCH  = 2'd1,
    S_CONFIRM = 2'd2,
    S_LOCKED  = 2'd3
  } state_t;

  state_t        r_state, w_state_next;
  logic          r_restart, w_restart_next;
  logic [6:0]    r_offset, w_offset_next;
  logic [GW-1:0] r_good_cnt, w_good_next, w_good_inc;
  logic [WW-1:0] r_win_cnt, w_win_next, w_win_inc;
  logic [BW-1:0] r_bad_cnt, w_bad_next, w_bad_inc;
  logic          w_hdr_ok;
  logic          w_unlock;

  assign w_hdr_ok   = hdr_i[1] ^ hdr_i[0];
  assign w_good_inc = r_good_cnt + GW'(1);
  assign w_win_inc  = r_win_cnt + WW'(1);
  assign w_bad_inc  = r_bad_cnt + BW'(!w_hdr_ok);

  always_comb begin
    w_state_next   = r_state;
    w_restart_next = 1'b0;
    w_offset_next  = r_offset;
    w_good_next    = r_good_cnt;
    w_win_next     = r_win_cnt;
    w_bad_next     = r_bad_cnt;
    w_unlock       = 1'b0;
    case (r_state)
      S_RESTART: begin
        // Stay here until the pulse has been presented once, so reset exit also produces it.
        w_good_next = '0;
        w_win_next  = '0;
        w_bad_next  = '0;
        if (r_restart) begin
          w_state_next = S_SEARCH;
        end else begin
          w_restart_next = 1'b1;
        end
      end
      S_SEARCH: begin
        if (seek_dv_i && seek_synced_i) begin
          w_offset_next = seek_offset_i;
          w_good_next   = '0;
          w_state_next  = S_CONFIRM;
        end
      end
      S_CONFIRM: begin
        if (hdr_dv_i) begin
          if (!w_hdr_ok) begin
            w_state_next   = S_RESTART;
            w_restart_next = 1'b1;
            w_good_next    = '0;
          end else if (w_good_inc == GW'(LOCK_CNT)) begin
            w_state_next = S_LOCKED;
            w_good_next  = '0;
            w_win_next   = '0;
            w_bad_next   = '0;
          end else begin
            w_good_next = w_good_inc;
          end
        end
      end
      S_LOCKED: begin
        if (hdr_dv_i) begin
          // Unlock takes priority over the window boundary.
          if (w_bad_inc == BW'(BAD_MAX)) begin
            w_state_next   = S_RESTART;
            w_restart_next = 1'b1;
            w_win_next     = '0;
            w_bad_next     = '0;
            w_unlock       = 1'b1;
          end else if (w_win_inc == WW'(WIN_LEN)) begin
            w_win_next = '0;
            w_bad_next = '0;
          end else begin
            w_win_next = w_win_inc;
            w_bad_next = w_bad_inc;
          end
        end
      end
      default: w_state_next = S_RESTART;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= S_RESTART;
      r_restart  <= 1'b0;
      r_offset   <= '0;
      r_good_cnt <= '0;
      r_win_cnt  <= '0;
      r_bad_cnt  <= '0;
    end else begin
      r_state    <= w_state_next;
      r_restart  <= w_restart_next;
      r_offset   <= w_offset_next;
      r_good_cnt <= w_good_next;
      r_win_cnt  <= w_win_next;
      r_bad_cnt  <= w_bad_next;
    end
  end

`ifdef SYNC_LOCK_STATS_EN
  logic [15:0] r_loss_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_loss_cnt <= '0;
    end else if (w_unlock && (r_loss_cnt != 16'hFFFF)) begin
      r_loss_cnt <= r_loss_cnt + 16'd1;
    end
  end

  assign lock_loss_cnt_o = r_loss_cnt;
`endif

  assign seek_restart_o = r_restart;
  assign offset_o       = r_offset;
  assign locked_o       = (r_state == S_LOCKED);
  assign state_o        = r_state;

endmodule

// File: doc/sync_lock_ctrl.md
SYNC_LOCK_CTRL -- requirements
Module: sync_lock_ctrl

Interface
REQ-001 Parameter LOCK_CNT, default 32, consecutive valid headers required to declare lock.
REQ-002 Parameter WIN_LEN, default 64, headers per monitoring window while locked.
REQ-003 Parameter BAD_MAX, default 16, invalid headers within one window that force loss of lock.
REQ-004 clk_i  input  1  single system clock, all logic rising-edge.
REQ-005 rst_ni  input  1  reset, asynchronous assert, active-low.
REQ-006 seek_synced_i  input  1  seeker reports candidate alignment found.
REQ-007 seek_offset_i  input  7  seeker candidate bit offset, 0..66.
REQ-008 seek_dv_i  input  1  seeker outputs valid this cycle.
REQ-009 hdr_i  input  2  sync header extracted at current offset_o.
REQ-010 hdr_dv_i  input  1  hdr_i valid this cycle.
REQ-011 seek_restart_o  output  1  one-cycle pulse restarting the seeker search.
REQ-012 offset_o  output  7  alignment offset applied to the gearbox.
REQ-013 locked_o  output  1  block lock achieved.
REQ-014 state_o  output  2  current FSM state encoding, for debug.

Function
REQ-015 FSM states SHALL be RESTART=0, SEARCH=1, CONFIRM=2, LOCKED=3.
REQ-016 RESTART: assert seek_restart_o for exactly one cycle; clear all counters; next state SEARCH.
REQ-017 SEARCH: on seek_dv_i & seek_synced_i, capture seek_offset_i into offset_o the next cycle; go to CONFIRM.
REQ-018 Header valid: hdr_i is 2'b01 or 2'b10; 2'b00 and 2'b11 are invalid.
REQ-019 CONFIRM: each hdr_dv_i with valid header increments good_cnt; any invalid header -> RESTART.
REQ-020 CONFIRM: when good_cnt reaches LOCK_CNT, go to LOCKED; locked_o rises in the same cycle the state register becomes LOCKED.
REQ-021 LOCKED: each hdr_dv_i increments win_cnt; each invalid header also increments bad_cnt.
REQ-022 LOCKED: when win_cnt reaches WIN_LEN, clear win_cnt and bad_cnt and remain LOCKED.
REQ-023 LOCKED: when bad_cnt reaches BAD_MAX, clear locked_o and go to RESTART.
REQ-024 Window end and bad_cnt reaching BAD_MAX in the same cycle: unlock wins.
REQ-025 offset_o SHALL hold constant in CONFIRM and LOCKED; seeker inputs are ignored outside SEARCH.
REQ-026 hdr_dv_i is ignored in RESTART and SEARCH.
REQ-027 Counters SHALL be sized to $clog2(param+1) bits and never wrap.
REQ-028 seek_restart_o SHALL never be asserted for two consecutive cycles.

Reset
REQ-029 On rst_ni low, immediately: state RESTART, offset_o=0, locked_o=0, seek_restart_o=0, all counters 0.
REQ-030 First cycle after deassertion SHALL be RESTART, producing the seek_restart_o pulse.
REQ-031 Reset asserted mid-CONFIRM or mid-LOCKED SHALL drop locked_o without waiting for a clock edge.

Configuration
REQ-032 Macro SYNC_LOCK_STATS_EN: when defined, output lock_loss_cnt_o, 16 bits, increments on every LOCKED->RESTART transition, saturates at 16'hFFFF, and resets to 0.
REQ-033 Without SYNC_LOCK_STATS_EN, the port and counter SHALL be absent; all other behaviour is identical.

Verification
REQ-034 Release reset -> seek_restart_o high for exactly 1 cycle, state_o=1 on the following cycle.
REQ-035 SEARCH, seek_dv_i=1, seek_synced_i=1, seek_offset_i=37 -> offset_o=37, state_o=2; then 32 headers of 2'b01 -> locked_o=1, state_o=3.
REQ-036 CONFIRM after 10 good headers, inject 2'b11 -> state RESTART, restart pulse, locked_o stays 0.
REQ-037 LOCKED, 15 bad in 64-header window -> stays locked, counters clear; then 16 bad within the next window -> locked_o=0, restart pulse.
REQ-038 16th bad header arrives as 64th header of the window -> unlock (priority check).
REQ-039 With SYNC_LOCK_STATS_EN, 3 lock/unlock cycles -> lock_loss_cnt_o=3; pulse rst_ni low -> 0 asynchronously.
